// File: rtl/loader_pkg.sv
// Shared loader types and constant helpers.
// The CSUM state exists only when PROG_LOADER_CSUM_EN is defined.
package loader_pkg;

   typedef enum logic [1:0] {
      ST_LOAD = 2'd0,
`ifdef PROG_LOADER_CSUM_EN
      ST_CSUM = 2'd1,
`endif
      ST_RUN  = 2'd2,
      ST_ERR  = 2'd3
   } state_e;

   // All-ones word of nbytes bytes, zero-extended to 32 bits.
   function automatic logic [31:0] all_ones(input int unsigned nbytes);
      if (nbytes >= 4) return 32'hFFFF_FFFF;
      return (32'h1 << (8 * nbytes)) - 32'h1;
   endfunction

   // Run-mode command that restarts loading.
   function automatic logic [31:0] reload_word(input int unsigned nbytes);
      return all_ones(nbytes) - 32'h1;
   endfunction

endpackage

// File: rtl/prog_loader_if.sv
// Byte input and memory/CPU-control outputs of the program loader.
// master = byte source / observer, slave = the loader.
interface prog_loader_if #(
   parameter int unsigned ADDR_W     = 12,
   parameter int unsigned WORD_BYTES = 2
);
   localparam int unsigned W = 8 * WORD_BYTES;

   logic [7:0]        rx_data;
   logic              rx_data_wr;
   logic              wr;
   logic [ADDR_W-1:0] addr;
   logic [W-1:0]      wr_data;
   logic              cpu_rst;
   logic [W-1:0]      run_data;
   logic              run_data_v;
   logic [ADDR_W-1:0] word_cnt;
   logic [1:0]        err;

   modport master (
      output rx_data, rx_data_wr,
      input  wr, addr, wr_data, cpu_rst, run_data, run_data_v, word_cnt, err
   );

   modport slave (
      input  rx_data, rx_data_wr,
      output wr, addr, wr_data, cpu_rst, run_data, run_data_v, word_cnt, err
   );
endinterface

// File: rtl/prog_loader_word_assembler.sv
// Byte-to-word assembler: phase counter plus shift register, first byte lands in the MSB.
// complete_c/word_c are combinational and valid in the strobe cycle of the last byte.
module word_assembler #(
   parameter int unsigned WORD_BYTES = 2
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    clr_i,
   input  logic [7:0]              byte_i,
   input  logic                    byte_v_i,
   output logic                    complete_c,
   output logic [8*WORD_BYTES-1:0] word_c
);
   localparam int unsigned W    = 8 * WORD_BYTES;
   localparam int unsigned PH_W = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
   localparam logic [PH_W-1:0] LAST_PH = PH_W'(WORD_BYTES - 1);

   logic [PH_W-1:0] phase_q;

   assign complete_c = byte_v_i && (phase_q == LAST_PH);

   // Clear wins over a concurrent byte so a state change always restarts at phase 0.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         phase_q <= '0;
      end else if (clr_i) begin
         phase_q <= '0;
      end else if (byte_v_i) begin
         phase_q <= (phase_q == LAST_PH) ? '0 : phase_q + PH_W'(1);
      end
   end

   if (WORD_BYTES > 1) begin : g_multi
      logic [W-9:0] shift_q;

      assign word_c = {shift_q, byte_i};

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            shift_q <= '0;
         end else if (byte_v_i) begin
            shift_q <= word_c[W-9:0];
         end
      end
   end else begin : g_single
      assign word_c = byte_i;
   end

endmodule

// File: rtl/prog_loader.sv
// Program loader: assembles UART bytes into words, writes them to program memory, then
// releases CPU reset. PROG_LOADER_CSUM_EN adds a checksum word after the terminator.
module prog_loader
   import loader_pkg::*;
#(
   parameter int unsigned ADDR_W      = 12,
   parameter int unsigned WORD_BYTES  = 2,
   parameter int unsigned START_ADDR  = 'h300,
   parameter int unsigned END_ADDR    = 'h7FE,
   parameter logic [31:0] RELOAD_WORD = reload_word(WORD_BYTES)
) (
   input logic          clk,
   input logic          rst,
   prog_loader_if.slave bus
);
   localparam int unsigned W = 8 * WORD_BYTES;
   localparam logic [W-1:0]      ONES_W   = W'(all_ones(WORD_BYTES));
   localparam logic [W-1:0]      RELOAD_W = W'(RELOAD_WORD);
   localparam logic [ADDR_W-1:0] START_A  = ADDR_W'(START_ADDR);
   localparam logic [ADDR_W-1:0] END_A    = ADDR_W'(END_ADDR);
   localparam logic [ADDR_W-1:0] STEP_A   = ADDR_W'(WORD_BYTES);

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              wrap_q, wrap_d;
   logic              wr_q, wr_d;
   logic [ADDR_W-1:0] out_addr_q, out_addr_d;
   logic [W-1:0]      wr_data_q, wr_data_d;
   logic              cpu_rst_q, cpu_rst_d;
   logic [W-1:0]      run_data_q, run_data_d;
   logic              run_data_v_q, run_data_v_d;
   logic [ADDR_W-1:0] word_cnt_q, word_cnt_d;
   logic [1:0]        err_q, err_d;
`ifdef PROG_LOADER_CSUM_EN
   logic [W-1:0]      csum_q, csum_d;
`endif

   logic              complete_c;
   logic [W-1:0]      word_c;
   logic              clr_c;
   logic              reload_c;
   logic [ADDR_W:0]   addr_sum_c;

   word_assembler #(
      .WORD_BYTES (WORD_BYTES)
   ) u_asm (
      .clk        (clk),
      .rst        (rst),
      .clr_i      (clr_c),
      .byte_i     (bus.rx_data),
      .byte_v_i   (bus.rx_data_wr),
      .complete_c (complete_c),
      .word_c     (word_c)
   );

   // Carry out of the address add marks an overflow before the wrapped value is ever used.
   assign addr_sum_c = {1'b0, addr_q} + {1'b0, STEP_A};
   assign reload_c   = complete_c && (word_c == RELOAD_W) &&
                       ((state_q == ST_RUN) || (state_q == ST_ERR));
   assign clr_c      = (state_d != state_q);

   // Next-state and registered-output logic.
   always_comb begin
      state_d      = state_q;
      addr_d       = addr_q;
      wrap_d       = wrap_q;
      wr_d         = 1'b0;
      out_addr_d   = out_addr_q;
      wr_data_d    = wr_data_q;
      run_data_d   = run_data_q;
      run_data_v_d = 1'b0;
      word_cnt_d   = word_cnt_q;
      err_d        = err_q;
`ifdef PROG_LOADER_CSUM_EN
      csum_d       = csum_q;
`endif

      if (complete_c) begin
         case (state_q)
            ST_LOAD: begin
               if (word_c == ONES_W) begin
`ifdef PROG_LOADER_CSUM_EN
                  state_d = ST_CSUM;
`else
                  state_d = ST_RUN;
`endif
               end else if (wrap_q || (addr_q > END_A)) begin
                  err_d[0] = 1'b1;
               end else begin
                  wr_d       = 1'b1;
                  out_addr_d = addr_q;
                  wr_data_d  = word_c;
                  addr_d     = addr_sum_c[ADDR_W-1:0];
                  wrap_d     = addr_sum_c[ADDR_W];
                  word_cnt_d = word_cnt_q + ADDR_W'(1);
`ifdef PROG_LOADER_CSUM_EN
                  csum_d     = csum_q + word_c;
`endif
               end
            end
`ifdef PROG_LOADER_CSUM_EN
            ST_CSUM: begin
               if (word_c == csum_q) begin
                  state_d = ST_RUN;
               end else begin
                  state_d  = ST_ERR;
                  err_d[1] = 1'b1;
               end
            end
`endif
            ST_RUN: begin
               if (!reload_c) begin
                  run_data_d   = word_c;
                  run_data_v_d = 1'b1;
               end
            end
            default: ;
         endcase
      end

      // Reload from RUN or ERR restarts a fresh load.
      if (reload_c) begin
         state_d    = ST_LOAD;
         addr_d     = START_A;
         wrap_d     = 1'b0;
         word_cnt_d = '0;
         err_d      = '0;
`ifdef PROG_LOADER_CSUM_EN
         csum_d     = '0;
`endif
      end

      cpu_rst_d = (state_d != ST_RUN);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_LOAD;
         addr_q       <= START_A;
         wrap_q       <= 1'b0;
         wr_q         <= 1'b0;
         out_addr_q   <= '0;
         wr_data_q    <= '0;
         cpu_rst_q    <= 1'b1;
         run_data_q   <= '0;
         run_data_v_q <= 1'b0;
         word_cnt_q   <= '0;
         err_q        <= '0;
      end else begin
         state_q      <= state_d;
         addr_q       <= addr_d;
         wrap_q       <= wrap_d;
         wr_q         <= wr_d;
         out_addr_q   <= out_addr_d;
         wr_data_q    <= wr_data_d;
         cpu_rst_q    <= cpu_rst_d;
         run_data_q   <= run_data_d;
         run_data_v_q <= run_data_v_d;
         word_cnt_q   <= word_cnt_d;
         err_q        <= err_d;
      end
   end

`ifdef PROG_LOADER_CSUM_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         csum_q <= '0;
      end else begin
         csum_q <= csum_d;
      end
   end
`endif

   assign bus.wr         = wr_q;
   assign bus.addr       = out_addr_q;
   assign bus.wr_data    = wr_data_q;
   assign bus.cpu_rst    = cpu_rst_q;
   assign bus.run_data   = run_data_q;
   assign bus.run_data_v = run_data_v_q;
   assign bus.word_cnt   = word_cnt_q;
   assign bus.err        = err_q;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: default build, a short END_ADDR build and a byte-wide build.
// Checksum scenarios run only when PROG_LOADER_CSUM_EN is defined.
module tb_prog_loader;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_checks = 0;
   int   n_errors = 0;
   int   nwr_a = 0;
   int   nwr_b = 0;
   int   nwr_c = 0;
   int   snap;

   always #5 clk = ~clk;

   prog_loader_if #(.ADDR_W(12), .WORD_BYTES(2)) ia ();
   prog_loader_if #(.ADDR_W(12), .WORD_BYTES(2)) ib ();
   prog_loader_if #(.ADDR_W(12), .WORD_BYTES(1)) ic ();

   prog_loader #(.ADDR_W(12), .WORD_BYTES(2)) dut_a (.clk(clk), .rst(rst), .bus(ia));
   prog_loader #(.ADDR_W(12), .WORD_BYTES(2), .END_ADDR('h302)) dut_b (.clk(clk), .rst(rst), .bus(ib));
   prog_loader #(.ADDR_W(12), .WORD_BYTES(1)) dut_c (.clk(clk), .rst(rst), .bus(ic));

   always @(negedge clk) begin
      if (ia.wr) nwr_a <= nwr_a + 1;
      if (ib.wr) nwr_b <= nwr_b + 1;
      if (ic.wr) nwr_c <= nwr_c + 1;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // One-cycle strobe to the selected loader; returns on the negedge after the capturing edge.
   task automatic send(input int sel, input logic [7:0] b);
      @(negedge clk);
      case (sel)
         0: begin ia.rx_data = b; ia.rx_data_wr = 1'b1; end
         1: begin ib.rx_data = b; ib.rx_data_wr = 1'b1; end
         default: begin ic.rx_data = b; ic.rx_data_wr = 1'b1; end
      endcase
      @(negedge clk);
      ia.rx_data_wr = 1'b0;
      ib.rx_data_wr = 1'b0;
      ic.rx_data_wr = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
      #1;
   endtask

   task automatic pulse_rst();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      ia.rx_data = 8'h00; ia.rx_data_wr = 1'b0;
      ib.rx_data = 8'h00; ib.rx_data_wr = 1'b0;
      ic.rx_data = 8'h00; ic.rx_data_wr = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      idle(1);

      check("rst_cpu_rst",  32'(ia.cpu_rst), 32'd1);
      check("rst_wr",       32'(ia.wr), 32'd0);
      check("rst_word_cnt", 32'(ia.word_cnt), 32'd0);
      check("rst_err",      32'(ia.err), 32'd0);
      check("rst_run_data", {31'd0, ia.run_data_v} | 32'(ia.run_data), 32'd0);

      // Basic load: 12 34 56 78 FF FF
      send(0, 8'h12);
      send(0, 8'h34);
      check("w0_wr",   32'(ia.wr), 32'd1);
      check("w0_addr", 32'(ia.addr), 32'h300);
      check("w0_data", 32'(ia.wr_data), 32'h1234);
      send(0, 8'h56);
      send(0, 8'h78);
      check("w1_wr",   32'(ia.wr), 32'd1);
      check("w1_addr", 32'(ia.addr), 32'h302);
      check("w1_data", 32'(ia.wr_data), 32'h5678);
      send(0, 8'hFF);
      check("term_half_cpu_rst", 32'(ia.cpu_rst), 32'd1);
      send(0, 8'hFF);
      check("term_no_wr", 32'(ia.wr), 32'd0);
`ifdef PROG_LOADER_CSUM_EN
      check("csum_wait_cpu_rst", 32'(ia.cpu_rst), 32'd1);
      send(0, 8'h68);
      send(0, 8'hAC);
`endif
      check("run_cpu_rst",  32'(ia.cpu_rst), 32'd0);
      check("run_word_cnt", 32'(ia.word_cnt), 32'd2);

      // Run-mode data word, then reload
      send(0, 8'hAB);
      send(0, 8'hCD);
      check("run_data",    32'(ia.run_data), 32'hABCD);
      check("run_data_v",  32'(ia.run_data_v), 32'd1);
      idle(1);
      check("run_data_v_pulse", 32'(ia.run_data_v), 32'd0);
      send(0, 8'hFF);
      send(0, 8'hFE);
      check("reload_cpu_rst", 32'(ia.cpu_rst), 32'd1);
      check("reload_no_v",    32'(ia.run_data_v), 32'd0);
      check("reload_cnt",     32'(ia.word_cnt), 32'd0);
      send(0, 8'h11);
      send(0, 8'h22);
      check("reload_addr", 32'(ia.addr), 32'h300);
      check("reload_data", 32'(ia.wr_data), 32'h1122);

      // Reset in the middle of a word drops the partial byte
      send(0, 8'h12);
      idle(1);
      snap = nwr_a;
      pulse_rst();
      idle(2);
      check("midrst_no_wr", 32'(nwr_a - snap), 32'd0);
      check("midrst_cnt",   32'(ia.word_cnt), 32'd0);
      send(0, 8'h34);
      send(0, 8'h56);
      check("midrst_wr",   32'(ia.wr), 32'd1);
      check("midrst_addr", 32'(ia.addr), 32'h300);
      check("midrst_data", 32'(ia.wr_data), 32'h3456);

      // END_ADDR = 'h302: third word overflows
      send(1, 8'h01); send(1, 8'h02);
      send(1, 8'h03); send(1, 8'h04);
      check("ovf_w1_addr", 32'(ib.addr), 32'h302);
      send(1, 8'h05); send(1, 8'h06);
      check("ovf_no_wr", 32'(ib.wr), 32'd0);
      check("ovf_err",   32'(ib.err), 32'd1);
      send(1, 8'hFF); send(1, 8'hFF);
`ifdef PROG_LOADER_CSUM_EN
      send(1, 8'h04); send(1, 8'h06);
`endif
      idle(2);
      check("ovf_nwr",     32'(nwr_b), 32'd2);
      check("ovf_cnt",     32'(ib.word_cnt), 32'd2);
      check("ovf_run",     32'(ib.cpu_rst), 32'd0);
      check("ovf_err_run", 32'(ib.err), 32'd1);

      // Byte-wide words
      send(2, 8'h7E);
      check("b1_wr",   32'(ic.wr), 32'd1);
      check("b1_addr", 32'(ic.addr), 32'h300);
      check("b1_data", 32'(ic.wr_data), 32'h7E);
      send(2, 8'hFF);
`ifdef PROG_LOADER_CSUM_EN
      send(2, 8'h7E);
`endif
      idle(1);
      check("b1_run", 32'(ic.cpu_rst), 32'd0);
      check("b1_nwr", 32'(nwr_c), 32'd1);

`ifdef PROG_LOADER_CSUM_EN
      // Checksum match then mismatch
      pulse_rst();
      send(0, 8'h00); send(0, 8'h01); send(0, 8'h00); send(0, 8'h02);
      send(0, 8'hFF); send(0, 8'hFF);
      send(0, 8'h00); send(0, 8'h03);
      check("csum_ok_run", 32'(ia.cpu_rst), 32'd0);
      check("csum_ok_err", 32'(ia.err), 32'd0);
      send(0, 8'hFF); send(0, 8'hFE);
      send(0, 8'h00); send(0, 8'h01); send(0, 8'h00); send(0, 8'h02);
      send(0, 8'hFF); send(0, 8'hFF);
      send(0, 8'h00); send(0, 8'h04);
      check("csum_bad_err", 32'(ia.err), 32'd2);
      check("csum_bad_rst", 32'(ia.cpu_rst), 32'd1);
      send(0, 8'hAB); send(0, 8'hCD);
      check("err_hold_rst", 32'(ia.cpu_rst), 32'd1);
      check("err_hold_v",   32'(ia.run_data_v), 32'd0);
      send(0, 8'hFF); send(0, 8'hFE);
      check("err_reload_err", 32'(ia.err), 32'd0);
      check("err_reload_rst", 32'(ia.cpu_rst), 32'd1);
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 Parameter ADDR_W, default 12: byte-address width of the memory port.
REQ-002 Parameter WORD_BYTES, default 2: bytes per word; word width W = 8*WORD_BYTES; legal values 1..4.
REQ-003 Parameter START_ADDR, default 'h300: first load address, WORD_BYTES-aligned.
REQ-004 Parameter END_ADDR, default 'h7FE: last writable word address, inclusive.
REQ-005 Parameter RELOAD_WORD, default all-ones minus 1 (16'hFFFE at W=16): run-mode command that restarts loading.
REQ-006 clk  in  1  system clock; single clock domain.
REQ-007 rst  in  1  asynchronous, active-high reset.
REQ-008 rx_data  in  8  received UART byte.
REQ-009 rx_data_wr  in  1  one-cycle strobe; rx_data is valid in that cycle.
REQ-010 wr  out  1  one-cycle memory write strobe.
REQ-011 addr  out  ADDR_W  memory byte address for wr.
REQ-012 wr_data  out  W  word to write; first received byte in the MSB.
REQ-013 cpu_rst  out  1  CPU reset; high in every state except RUN.
REQ-014 run_data  out  W  last word received in RUN.
REQ-015 run_data_v  out  1  one-cycle pulse when run_data updates.
REQ-016 word_cnt  out  ADDR_W  number of words written in the current load.
REQ-017 err  out  2  sticky status: bit0 = address overflow, bit1 = checksum mismatch.

Function
REQ-018 States: LOAD, CSUM (macro only), RUN, ERR; reset state is LOAD.
REQ-019 Byte phase counter: 0..WORD_BYTES-1, advances on rx_data_wr, wraps to 0; shift register is shifted left by 8 with rx_data inserted in the LSB.
REQ-020 Word completes on the rx_data_wr where phase == WORD_BYTES-1; all following actions occur on the next clock edge (latency 1).
REQ-021 LOAD, complete word != all-ones, address <= END_ADDR: wr=1, addr=current address, wr_data=word; address += WORD_BYTES; word_cnt += 1.
REQ-022 LOAD, address > END_ADDR: no wr; err[0] is set; words continue to be consumed until the terminator.
REQ-023 LOAD, complete word == all-ones: no wr; go to CSUM if the macro is defined, otherwise RUN.
REQ-024 RUN, complete word == RELOAD_WORD: go to LOAD; address=START_ADDR; word_cnt=0; err cleared; no run_data_v.
REQ-025 RUN, any other complete word: run_data=word; run_data_v=1 for one cycle.
REQ-026 cpu_rst is registered; it drops on the same edge the state becomes RUN and rises on the same edge RUN is left.
REQ-027 Entering LOAD and entering RUN both reset the byte phase to 0; a partial word is discarded.
REQ-028 Address arithmetic is ADDR_W bits; overflow is detected before wrap, so no write is issued at a wrapped address.
REQ-029 ERR: cpu_rst=1; only RELOAD_WORD leaves ERR (to LOAD, as REQ-024).

Reset
REQ-030 rst asserted: state=LOAD, phase=0, address=START_ADDR, wr=0, cpu_rst=1, run_data=0, run_data_v=0, word_cnt=0, err=0, checksum=0.
REQ-031 rst asserted mid-word or mid-load discards all progress; there is no write on the reset edge.

Configuration
REQ-032 Macro PROG_LOADER_CSUM_EN.
- Defined: the loader keeps a W-bit modulo-2^W sum of every word written. In CSUM, the next complete word is compared with this sum: equal goes to RUN; unequal goes to ERR with err[1] set.
- Undefined: there is no CSUM state, no checksum register, and err[1] is tied to 0.

Structure
REQ-033 The state enum and the all-ones and RELOAD_WORD constant functions live in the shared package loader_pkg.
REQ-034 One sub-module, word_assembler (phase counter, shift register, complete pulse), is instantiated once.

Verification
REQ-035 W=16: bytes 12 34 56 78 FF FF -> writes 'h1234@'h300, 'h5678@'h302; cpu_rst falls 1 cycle after the last FF; word_cnt=2.
REQ-036 RUN: bytes AB CD -> run_data='hABCD with a one-cycle run_data_v; bytes FF FE -> cpu_rst=1, next word written at 'h300.
REQ-037 END_ADDR='h302: 3 words then FF FF -> only 2 writes, err[0]=1, RUN entered.
REQ-038 PROG_LOADER_CSUM_EN defined: 00 01 00 02 FF FF 00 03 -> RUN; same stream ending 00 04 -> ERR with err=2'b10 and cpu_rst held at 1.
REQ-039 rst pulsed after byte 12 of a word: no wr; the next 34 56 writes 'h3456@'h300.
REQ-040 WORD_BYTES=1: bytes 7E FF -> one write of 'h7E@'h300, then RUN.
